// File: rtl/axis_batch_pkg.sv
// Shared types and the TLAST decision for the batch framer.
package axis_batch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int MAX_BATCH = 65535;
  localparam int IDX_MAX_W = $clog2(MAX_BATCH + 1);

  typedef logic [IDX_MAX_W-1:0] beat_idx_t;

  function automatic logic is_last(input beat_idx_t idx, input beat_idx_t last_idx,
                                   input logic flush_p, input logic flush);
    return (idx == last_idx) || flush_p || flush;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice with registered upstream ready; a tag bit is
// latched alongside the data whenever a beat enters the output register.
//   state | meaning
//   EMPTY | output register and skid register empty
//   BUSY  | output register holds a beat, skid empty
//   FULL  | both registers hold a beat, upstream ready held low
module axis_skid_buffer
  import axis_batch_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src_data,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic         load_tag,
  output logic [W-1:0] dst_data,
  output logic         dst_tag,
  output logic         dst_valid,
  input  logic         dst_ready,
  output logic         load
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_BUSY  = BUSY;
  localparam logic [1:0] ST_FULL  = FULL;

  logic [1:0]   state;
  logic [1:0]   state_n;
  logic [W-1:0] skid_data;
  logic         from_skid;
  logic         accept;
  logic         xfer;

  assign accept = src_valid && src_ready;
  assign xfer   = dst_valid && dst_ready;

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n = ST_BUSY;
          load    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (accept && xfer) begin
          load = 1'b1;
        end else if (accept) begin
          state_n = ST_FULL;
        end else if (xfer) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer) begin
          state_n   = ST_BUSY;
          load      = 1'b1;
          from_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      src_ready <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_tag   <= 1'b0;
      skid_data <= '0;
    end else begin
      state     <= state_n;
      src_ready <= (state_n != ST_FULL);
      dst_valid <= (state_n == ST_BUSY) || (state_n == ST_FULL);
      if (load) begin
        dst_data <= from_skid ? skid_data : src_data;
        dst_tag  <= load_tag;
      end
      // the only path into the skid is an accept while the output is stalled
      if ((state == ST_BUSY) && accept && !xfer) begin
        skid_data <= src_data;
      end
    end
  end

endmodule

// File: rtl/axis_batch_framer.sv
// AXI-Stream framer: re-times beats through a skid buffer and asserts TLAST
// every BATCH_SIZE beats or early on flush; counts completed batches.
module axis_batch_framer
  import axis_batch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BATCH_SIZE = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DATA_WIDTH-1:0] s_axis_input_tdata,
  input  logic                  s_axis_input_tvalid,
  output logic                  s_axis_input_tready,
  output logic [DATA_WIDTH-1:0] m_axis_output_tdata,
  output logic                  m_axis_output_tvalid,
  output logic                  m_axis_output_tlast,
  input  logic                  m_axis_output_tready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  batch_count
);

  localparam int IDX_W = $clog2(BATCH_SIZE + 1);

  logic [IDX_W-1:0] beat_idx;
  logic             flush_pending;
  logic             load;
  logic             tlast;

  // tlast is decided when a beat enters the output register, so a flush
  // raised while a beat waits in the skid still closes the batch on it
  assign tlast = is_last(beat_idx_t'(beat_idx), beat_idx_t'(BATCH_SIZE - 1),
                         flush_pending, flush);

  axis_skid_buffer #(
    .W (DATA_WIDTH)
  ) u_skid (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .src_data  (s_axis_input_tdata),
    .src_valid (s_axis_input_tvalid),
    .src_ready (s_axis_input_tready),
    .load_tag  (tlast),
    .dst_data  (m_axis_output_tdata),
    .dst_tag   (m_axis_output_tlast),
    .dst_valid (m_axis_output_tvalid),
    .dst_ready (m_axis_output_tready),
    .load      (load)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      beat_idx      <= '0;
      flush_pending <= 1'b0;
    end else if (load) begin
      beat_idx <= tlast ? '0 : beat_idx + IDX_W'(1);
      if (tlast) begin
        flush_pending <= 1'b0;
      end
    end else if (flush) begin
      flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      batch_count <= '0;
    end else if (m_axis_output_tvalid && m_axis_output_tready && m_axis_output_tlast) begin
      batch_count <= batch_count + CNT_WIDTH'(1);
    end
  end

endmodule
